// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 round sequencer and its datapath:
// controller state encoding, round/nonce geometry.
package sha_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int ROUND_BITS = 7;
  localparam int NONCE_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ROUNDS = 3'd2,
    ST_FINAL  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FOUND  = 3'd5
  } sha_ctrl_state_t;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Job/datapath bundle of the round controller: slave is the controller,
// master is whoever drives the job side and models the datapath.
interface sha256_round_ctrl_if;
  import sha_pkg::*;

  logic                  start;
  logic                  abort;
  logic [NONCE_BITS-1:0] nonce_start;
  logic [NONCE_BITS-1:0] nonce_end;
  logic                  below_target;
  logic                  found_ack;
  logic                  init_regs;
  logic                  round_en;
  logic [ROUND_BITS-1:0] round_idx;
  logic                  final_add;
  logic [NONCE_BITS-1:0] nonce;
  logic                  busy;
  logic                  found;
  logic                  exhausted;

  modport slave (
    input  start, abort, nonce_start, nonce_end, below_target, found_ack,
    output init_regs, round_en, round_idx, final_add, nonce, busy, found, exhausted
  );

  modport master (
    output start, abort, nonce_start, nonce_end, below_target, found_ack,
    input  init_regs, round_en, round_idx, final_add, nonce, busy, found, exhausted
  );

endinterface

// File: rtl/sha256_round_ctrl_counter.sv
// Generic up-counter: restart loads RESTART_VAL, enable counts up and
// saturates at MAX_VAL; complete flags the enabled cycle sitting at MAX_VAL.
module sha256_round_ctrl_counter #(
  parameter int                NUM_BITS    = 7,
  parameter logic [NUM_BITS-1:0] RESTART_VAL = {NUM_BITS{1'b0}},
  parameter logic [NUM_BITS-1:0] MAX_VAL     = {NUM_BITS{1'b1}}
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable_i,
  input  logic                restart_i,
  output logic [NUM_BITS-1:0] count_o,
  output logic                complete_o
);

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_d;
  logic                at_max_s;

  assign at_max_s   = (count_q == MAX_VAL);
  assign complete_o = enable_i & at_max_s;
  assign count_o    = count_q;

  // Next count: restart wins, otherwise step until MAX_VAL and hold there.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = RESTART_VAL;
    end else if (enable_i && !at_max_s) begin
      count_d = count_q + {{(NUM_BITS-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= {NUM_BITS{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Nonce-range sequencer for one SHA-256 core: per nonce it drives init,
// 64 rounds, final add and the target check, then reports found/exhausted.
module sha256_round_ctrl
  import sha_pkg::*;
(
  input logic               clk,
  input logic               n_rst,
  sha256_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_INIT   = ST_INIT;
  localparam logic [2:0] S_ROUNDS = ST_ROUNDS;
  localparam logic [2:0] S_FINAL  = ST_FINAL;
  localparam logic [2:0] S_CHECK  = ST_CHECK;
  localparam logic [2:0] S_FOUND  = ST_FOUND;

  logic [2:0]            state_q, state_d;
  logic [NONCE_BITS-1:0] nonce_q, nonce_d;
  logic [NONCE_BITS-1:0] end_q, end_d;
  logic                  found_q, found_d;
  logic                  exhausted_q, exhausted_d;

  logic                  init_regs_s;
  logic                  round_en_s;
  logic                  final_add_s;
  logic                  round_done_s;
  logic [ROUND_BITS-1:0] round_idx_s;

  sha256_round_ctrl_counter #(
    .NUM_BITS    (ROUND_BITS),
    .RESTART_VAL ({ROUND_BITS{1'b0}}),
    .MAX_VAL     (ROUND_BITS'(NUM_ROUNDS - 1))
  ) u_round_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable_i   (round_en_s),
    .restart_i  (init_regs_s),
    .count_o    (round_idx_s),
    .complete_o (round_done_s)
  );

  // Moore decode of the datapath strobes from the registered state.
  always_comb begin
    init_regs_s = 1'b0;
    round_en_s  = 1'b0;
    final_add_s = 1'b0;
    case (state_q)
      S_INIT:   init_regs_s = 1'b1;
      S_ROUNDS: round_en_s  = 1'b1;
      S_FINAL:  final_add_s = 1'b1;
      default: begin
        init_regs_s = 1'b0;
        round_en_s  = 1'b0;
        final_add_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; abort overrides every transition but leaves nonce alone.
  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    end_d       = end_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    if (bus.abort) begin
      state_d     = S_IDLE;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            nonce_d     = bus.nonce_start;
            end_d       = bus.nonce_end;
            exhausted_d = 1'b0;
            state_d     = S_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INIT:   state_d = S_ROUNDS;
        S_ROUNDS: begin
          if (round_done_s) begin
            state_d = S_FINAL;
          end else begin
            state_d = S_ROUNDS;
          end
        end
        S_FINAL:  state_d = S_CHECK;
        S_CHECK: begin
          // A hit on the last nonce reports found, never exhausted.
          if (bus.below_target) begin
            found_d = 1'b1;
            state_d = S_FOUND;
          end else if (nonce_q == end_q) begin
            exhausted_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            nonce_d = nonce_q + {{(NONCE_BITS-1){1'b0}}, 1'b1};
            state_d = S_INIT;
          end
        end
        S_FOUND: begin
          if (bus.found_ack) begin
            found_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_FOUND;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, nonce range and result flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      nonce_q     <= {NONCE_BITS{1'b0}};
      end_q       <= {NONCE_BITS{1'b0}};
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      end_q       <= end_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign bus.init_regs = init_regs_s;
  assign bus.round_en  = round_en_s;
  assign bus.final_add = final_add_s;
  assign bus.round_idx = round_idx_s;
  assign bus.nonce     = nonce_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.found     = found_q;
  assign bus.exhausted = exhausted_q;

endmodule
